// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding and Booth recoding constants
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Recoding of {Q[0], Q_1}; 2'b11 is a second no-op pattern.
  localparam logic [1:0] BOOTH_NOP     = 2'b00;
  localparam logic [1:0] BOOTH_ADD     = 2'b01;
  localparam logic [1:0] BOOTH_SUB     = 2'b10;
  localparam logic [1:0] BOOTH_NOP_ALT = 2'b11;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth step: add/subtract M then arithmetic shift
module booth_step
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W+1:0] a_i,
  input  logic [W:0]   q_i,
  input  logic         q1_i,
  input  logic [W:0]   m_i,
  output logic [W+1:0] a_o,
  output logic [W:0]   q_o,
  output logic         q1_o
);

  logic [W+1:0] m_ext;
  logic [W+1:0] sum;

  // The extra MSB on A keeps A - M from overflowing for any extended M.
  assign m_ext = {m_i[W], m_i};

  always_comb begin
    sum = a_i;
    case ({q_i[0], q1_i})
      BOOTH_ADD:     sum = a_i + m_ext;
      BOOTH_SUB:     sum = a_i - m_ext;
      BOOTH_NOP,
      BOOTH_NOP_ALT: sum = a_i;
      default:       sum = a_i;
    endcase
  end

  assign a_o  = {sum[W+1], sum[W+1:1]};
  assign q_o  = {sum[0], q_i[W:1]};
  assign q1_o = q_i[0];

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with valid/ready on both sides
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy
);

  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] LAST_STEP = CW'(W);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [W+1:0]     a_q;
  logic [W+1:0]     a_d;
  logic [W:0]       q_q;
  logic [W:0]       q_d;
  logic             q1_q;
  logic             q1_d;
  logic [W:0]       m_q;
  logic [2*W-1:0]   p_q;
  logic [W:0]       a_ext;
  logic [W:0]       b_ext;

  // Operands are widened by one bit so unsigned values look non-negative to Booth.
  assign a_ext = {in_signed & in_a[W-1], in_a};
  assign b_ext = {in_signed & in_b[W-1], in_b};

  booth_step #(.W(W)) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (a_d),
    .q_o  (q_d),
    .q1_o (q1_d)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      p_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            m_q     <= a_ext;
            q_q     <= b_ext;
            q1_q    <= 1'b0;
            a_q     <= '0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            // Low 2W bits of {A,Q} after the final shift are the exact product.
            p_q     <= {a_d[W-2:0], q_d};
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_p     = p_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - directed and back-to-back checks of booth_mult_seq at W=4 and W=8
module tb_booth_mult_seq;

  logic        clk;
  logic        n_rst;

  logic        in_valid4, in_ready4, in_signed4, out_valid4, out_ready4, busy4;
  logic [3:0]  in_a4, in_b4;
  logic [7:0]  out_p4;

  logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, busy8;
  logic [7:0]  in_a8, in_b8;
  logic [15:0] out_p8;

  int errors;
  int checks;
  int cyc;

  booth_mult_seq #(.W(4)) u_dut4 (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_a      (in_a4),
    .in_b      (in_b4),
    .in_signed (in_signed4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_p     (out_p4),
    .busy      (busy4)
  );

  booth_mult_seq #(.W(8)) u_dut8 (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_a      (in_a8),
    .in_b      (in_b8),
    .in_signed (in_signed8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_p     (out_p8),
    .busy      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic s, output int lat);
    in_a4 = a; in_b4 = b; in_signed4 = s; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish4;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
    in_a8 = a; in_b8 = b; in_signed8 = s; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_signed4 = 0; out_ready4 = 0;
    in_valid8 = 0; in_a8 = 0; in_b8 = 0; in_signed8 = 0; out_ready8 = 0;
    #12;
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready4: got %b expected 1", in_ready4); end
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid4: got %b expected 0", out_valid4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
    checks++; if (out_p4 !== 8'h00) begin errors++; $display("FAIL reset_out_p4: got %h expected 00", out_p4); end
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b expected 1", in_ready8); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %b expected 0", out_valid8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
    checks++; if (out_p8 !== 16'h0000) begin errors++; $display("FAIL reset_out_p8: got %h expected 0000", out_p8); end
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_signed_basic;
    int lat;
    start4(4'd3, 4'hE, 1'b1, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    checks++; if (out_p4 !== 8'hFA) begin errors++; $display("FAIL basic_product: got %h expected fa", out_p4); end
    checks++; if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin errors++; $display("FAIL basic_done_flags: got busy=%b in_ready=%b expected busy=1 in_ready=0", busy4, in_ready4); end
    finish4();
    checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin errors++; $display("FAIL basic_return_idle: got out_valid=%b in_ready=%b busy=%b expected 0 1 0", out_valid4, in_ready4, busy4); end
    checks++; if (out_p4 !== 8'hFA) begin errors++; $display("FAIL basic_product_held: got %h expected fa", out_p4); end
  endtask

  task automatic test_mode;
    logic [7:0] exp_p [2];
    int lat;
    exp_p[0] = 8'hE1;
    exp_p[1] = 8'h01;
    for (int m = 0; m < 2; m++) begin
      start4(4'hF, 4'hF, m[0], lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL mode%0d_latency: got %0d expected 5", m, lat); end
      checks++; if (out_p4 !== exp_p[m]) begin errors++; $display("FAIL mode%0d_product: got %h expected %h", m, out_p4, exp_p[m]); end
      finish4();
    end
  endtask

  task automatic test_signed_corners;
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [7:0] vp [3];
    int lat;
    va[0] = 4'h8; vb[0] = 4'h8; vp[0] = 8'h40;
    va[1] = 4'h8; vb[1] = 4'h7; vp[1] = 8'hC8;
    va[2] = 4'h0; vb[2] = 4'h8; vp[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      start4(va[i], vb[i], 1'b1, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL corner%0d_latency: got %0d expected 5", i, lat); end
      checks++; if (out_p4 !== vp[i]) begin errors++; $display("FAIL corner%0d_product: got %h expected %h", i, out_p4, vp[i]); end
      finish4();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    start8(8'd200, 8'd100, 1'b0, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL bp_latency: got %0d expected 9", lat); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_a8 = 8'd7; in_b8 = 8'd9; in_signed8 = 1'b1; in_valid8 = 1'b1;
      end
      checks++; if (out_p8 !== 16'h4E20 || out_valid8 !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got p=%h valid=%b expected p=4e20 valid=1", i, out_p8, out_valid8); end
      checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b expected 0", i, in_ready8); end
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    checks++; if (out_p8 !== 16'h4E20 || out_valid8 !== 1'b1) begin errors++; $display("FAIL bp_before_release: got p=%h valid=%b expected p=4e20 valid=1", out_p8, out_valid8); end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b busy=%b expected 0 1 0", out_valid8, in_ready8, busy8); end
    checks++; if (out_p8 !== 16'h4E20) begin errors++; $display("FAIL bp_product_kept: got %h expected 4e20", out_p8); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    in_a8 = 8'd7; in_b8 = 8'd9; in_signed8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_rst = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0 || in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin errors++; $display("FAIL midrst_flags: got busy=%b in_ready=%b out_valid=%b expected 0 1 0", busy8, in_ready8, out_valid8); end
    checks++; if (out_p8 !== 16'h0000) begin errors++; $display("FAIL midrst_out_p: got %h expected 0000", out_p8); end
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    start8(8'd5, 8'd6, 1'b1, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL midrst_next_latency: got %0d expected 9", lat); end
    checks++; if (out_p8 !== 16'h001E) begin errors++; $display("FAIL midrst_next_product: got %h expected 001e", out_p8); end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0]  a, b;
    logic        s;
    logic [15:0] exp_p;
    int ia, ib, prod, n, acc, prev_acc;
    bit first;
    first = 1'b1;
    prev_acc = 0;
    out_ready8 = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 256; k++) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        s = m[0];
        ia = s ? {{24{a[7]}}, a} : {24'd0, a};
        ib = s ? {{24{b[7]}}, b} : {24'd0, b};
        prod = ia * ib;
        exp_p = prod[15:0];
        in_a8 = a; in_b8 = b; in_signed8 = s; in_valid8 = 1'b1;
        n = 0;
        while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        acc = cyc;
        if (!first) begin
          checks++; if (acc - prev_acc !== 11) begin errors++; $display("FAIL b2b_spacing m%0d k%0d: got %0d expected 11", m, k, acc - prev_acc); end
        end
        first = 1'b0;
        prev_acc = acc;
        n = 0;
        while (!out_valid8 && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (out_valid8 !== 1'b1 || out_p8 !== exp_p) begin errors++; $display("FAIL b2b_product m%0d k%0d: a=%h b=%h got %h valid=%b expected %h", m, k, a, b, out_p8, out_valid8, exp_p); end
      end
    end
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    test_reset();
    test_signed_basic();
    test_mode();
    test_signed_corners();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier with valid/ready handshakes on both sides and a per-transaction signed/unsigned mode. It accepts one operand pair, runs one Booth step per clock for a fixed W+1 cycles, then holds the 2W-bit product until the consumer takes it. It is the general-width arithmetic core for datapath blocks that share a multiplier and need to tolerate backpressure.

## Interface
- W, default 8: operand width, W ≥ 2; product is 2W bits.
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair and mode are valid.
- in_ready  out  1  block can accept an operand pair; high only in IDLE.
- in_a  in  W  multiplicand (M).
- in_b  in  W  multiplier (Q).
- in_signed  in  1  1 = both operands are two's complement; 0 = both are unsigned.
- out_valid  out  1  product valid; high only in DONE.
- out_ready  in  1  consumer accepts the product.
- out_p  out  2W  product, exact, no truncation or overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE → RUN on in_valid & in_ready.
  - RUN → DONE after the step counter completes W+1 steps.
  - DONE → IDLE on out_valid & out_ready.
- Accept, on the input handshake edge:
  - Extend in_a and in_b to W+1 bits: sign-extend if in_signed, else zero-extend.
  - M ← ext(in_a); Q ← ext(in_b); Q_1 ← 0; A ← 0; counter ← 0.
  - The mode is latched; in_signed is ignored after acceptance.
- A is W+2 bits wide, so A−M never overflows.
  - M is sign-extended to W+2 bits for the add/subtract.
- Booth step, one per RUN cycle, selected on {Q[0],Q_1}:
  - 10: A ← A − M.
  - 01: A ← A + M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,Q_1} by one, replicating A's MSB.
- On the final step, register out_p ← low 2W bits of {A,Q} after that step's shift.
- out_p and out_valid hold stable in DONE until out_ready is sampled high.
- out_p keeps its last value after leaving DONE and is only overwritten by the next completion.
- While busy, in_valid and all operand inputs are ignored; in_ready stays 0.
- All state, counter, datapath and output registers reset asynchronously.
  - Reset mid-RUN or mid-DONE discards the transaction and returns to IDLE.
  - No partial result is ever presented.

## Timing
- Reset values: out_valid 0, out_p 0, busy 0, in_ready 1 (state IDLE); counter and A/Q/Q_1/M all 0.
- Latency: operands accepted at edge e0; RUN steps on edges e1…e(W+1); out_valid first high after e(W+1). This is fixed at W+1 cycles for both modes and all operand values.
- Throughput with out_ready held high: one product per W+3 cycles:
  - e0 accept.
  - W+1 RUN edges.
  - Output handshake edge (DONE → IDLE).
  - in_ready high the cycle after, next accept edge.
- in_ready, out_valid and busy are decoded directly from the state register; there is no combinational path from in_valid or out_ready to any output.
- Counter width is $clog2(W+2); the counter does not wrap within a transaction.

## Structure
- Package booth_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the Booth encoding constants for {Q[0],Q_1} (NOP, ADD, SUB).
- Sub-module booth_step, combinational, parametrised on width:
  - inputs: A, Q, Q_1, M;
  - outputs: next A, Q, Q_1 after add/subtract and arithmetic shift.
- The top level holds the FSM, the counter, operand extension and the output register.

## Test plan
- W=4, signed, in_a=3, in_b=−2 (4'hE) → out_p=8'hFA (−6); out_valid rises exactly 5 cycles after the accept edge.
- W=4, unsigned, in_a=15, in_b=15 → out_p=8'hE1 (225). With signed mode on the same bits, −1×−1 → out_p=8'h01.
- W=4, signed corners:
  - −8 × −8 → 8'h40;
  - −8 × 7 → 8'hC8;
  - 0 × −8 → 8'h00.
- W=8 backpressure: unsigned 200×100.
  - Hold out_ready=0 for 10 cycles → out_p=16'h4E20, stable with out_valid high throughout.
  - in_ready stays 0 and a new in_valid is ignored.
  - Releasing out_ready completes the handshake and returns to IDLE.
- Reset mid-RUN: pulse n_rst low during step 3 → all outputs return to reset values immediately; the next transaction 5×6 (W=8, signed) yields 16'h001E.
- Back-to-back: in_valid and out_ready held high, 256 random operand pairs per mode at W=8 compared against a reference model; the accept-to-accept spacing is exactly W+3 = 11 cycles.
